// File: rtl/pipe_pkg.sv
// ============================================================================
// pipe_pkg : shared halt-FSM encoding and counter width for pipeline_chain
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pipe_state_t;

    localparam int PIPE_CNT_W = 32;

    function automatic logic [PIPE_CNT_W-1:0] sat_inc(input logic [PIPE_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_slot.sv
// ============================================================================
// pipe_slot : one pipeline stage register (valid, halt marker, payload)
// Revision  : 1.0
// ============================================================================
`default_nettype none

module pipe_slot
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             load,
    input  logic             clear,
    input  logic             next_valid,
    input  logic             next_halt,
    input  logic [WIDTH-1:0] next_data,
    output logic             valid,
    output logic             halt,
    output logic [WIDTH-1:0] data
);

    // clear masks the qualifiers only; payload follows load
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            valid <= 1'b0;
            halt  <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= next_valid & ~clear;
            halt  <= next_halt & ~clear;
            data  <= next_data;
        end else if (clear) begin
            valid <= 1'b0;
            halt  <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipeline_chain.sv
// ============================================================================
// pipeline_chain : DEPTH-stage shift pipeline with stall, bubble, flush and
//                  halt drain; PIPE_PERF_EN adds saturating event counters
// Revision       : 1.0
// ============================================================================
`default_nettype none

module pipeline_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_halt,
    output logic                     in_ready,
    input  logic                     stall,
    input  logic                     bubble_req,
    input  logic [$clog2(DEPTH)-1:0] bubble_stage,
    input  logic                     flush_req,
    input  logic [$clog2(DEPTH)-1:0] flush_stage,
    output logic [DEPTH-1:0]         stage_valid,
    output logic [DEPTH*WIDTH-1:0]   stage_data,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     halted,
    output logic [1:0]               state
`ifdef PIPE_PERF_EN
    ,
    output logic [PIPE_CNT_W-1:0]    stall_cnt,
    output logic [PIPE_CNT_W-1:0]    bubble_cnt,
    output logic [PIPE_CNT_W-1:0]    flush_cnt
`endif
);

    pipe_state_t      r_state;
    pipe_state_t      w_next_state;
    logic             r_halted;

    logic [DEPTH-1:0] w_load;
    logic [DEPTH-1:0] w_clear;
    logic [DEPTH-1:0] w_nv;
    logic [DEPTH-1:0] w_nh;
    logic [WIDTH-1:0] w_nd [DEPTH];
    logic [DEPTH-1:0] w_sv;
    logic [DEPTH-1:0] w_sh;
    logic [WIDTH-1:0] w_sd [DEPTH];

    logic             w_accept;
    logic             w_halt_at_end;
    logic             w_halt_survives;

    assign in_ready      = !stall && !bubble_req && !flush_req && (r_state == RUN);
    assign w_accept      = in_valid & in_ready;
    assign w_halt_at_end = w_sv[DEPTH-1] & w_sh[DEPTH-1];

    always_comb begin
        w_load  = '0;
        w_clear = '0;
        w_nv    = '0;
        w_nh    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_nd[k] = '0;
        end
        if (!stall) begin
            w_load  = '1;
            w_nv[0] = w_accept;
            w_nh[0] = in_halt & w_accept;
            w_nd[0] = in_data;
            for (int k = 1; k < DEPTH; k++) begin
                w_nv[k] = w_sv[k-1];
                w_nh[k] = w_sh[k-1];
                w_nd[k] = w_sd[k-1];
            end
            if (flush_req) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (k <= int'(flush_stage)) begin
                        w_clear[k] = 1'b1;
                    end
                end
            end else if (bubble_req) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (k < int'(bubble_stage)) begin
                        w_load[k] = 1'b0;
                    end else if (k == int'(bubble_stage)) begin
                        w_clear[k] = 1'b1;
                        w_nd[k]    = '0;
                    end
                end
            end
        end
    end

    // Does any halt marker land beyond the flushed region this cycle?
    always_comb begin
        w_halt_survives = 1'b0;
        for (int k = 1; k < DEPTH; k++) begin
            if (k > int'(flush_stage) && w_sv[k-1] && w_sh[k-1]) begin
                w_halt_survives = 1'b1;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_slot
            pipe_slot #(
                .WIDTH (WIDTH)
            ) u_slot (
                .CLK        (CLK),
                .nRST       (nRST),
                .load       (w_load[g]),
                .clear      (w_clear[g]),
                .next_valid (w_nv[g]),
                .next_halt  (w_nh[g]),
                .next_data  (w_nd[g]),
                .valid      (w_sv[g]),
                .halt       (w_sh[g]),
                .data       (w_sd[g])
            );
            assign stage_data[g*WIDTH +: WIDTH] = w_sd[g];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state  <= RUN;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_halted <= (w_next_state == HALTED);
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (!stall) begin
            case (r_state)
                RUN: begin
                    if (w_accept && in_halt) begin
                        w_next_state = DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_halt_at_end) begin
                        w_next_state = HALTED;
                    end else if (flush_req && !w_halt_survives) begin
                        w_next_state = RUN;
                    end
                end
                HALTED:  w_next_state = HALTED;
                default: w_next_state = RUN;
            endcase
        end
    end

`ifdef PIPE_PERF_EN
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else if (r_state != HALTED) begin
            if (stall) begin
                stall_cnt <= sat_inc(stall_cnt);
            end else if (flush_req) begin
                flush_cnt <= sat_inc(flush_cnt);
            end else if (bubble_req) begin
                bubble_cnt <= sat_inc(bubble_cnt);
            end
        end
    end
`endif

    assign stage_valid = w_sv;
    assign out_valid   = w_sv[DEPTH-1];
    assign out_data    = w_sd[DEPTH-1];
    assign halted      = r_halted;
    assign state       = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_chain.sv
// ============================================================================
// tb_pipeline_chain : scoreboard bench for pipeline_chain (DEPTH=4, WIDTH=32)
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_chain;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic               CLK = 1'b0;
    logic               nRST;
    logic               in_valid;
    logic [WIDTH-1:0]   in_data;
    logic               in_halt;
    logic               in_ready;
    logic               stall;
    logic               bubble_req;
    logic [1:0]         bubble_stage;
    logic               flush_req;
    logic [1:0]         flush_stage;
    logic [DEPTH-1:0]   stage_valid;
    logic [DEPTH*WIDTH-1:0] stage_data;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               halted;
    logic [1:0]         state;
`ifdef PIPE_PERF_EN
    logic [31:0]        stall_cnt;
    logic [31:0]        bubble_cnt;
    logic [31:0]        flush_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_popped = 0;
    bit sb_en    = 1'b0;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               due;
    } sb_item_t;
    sb_item_t exp_q[$];

    pipeline_chain #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_halt      (in_halt),
        .in_ready     (in_ready),
        .stall        (stall),
        .bubble_req   (bubble_req),
        .bubble_stage (bubble_stage),
        .flush_req    (flush_req),
        .flush_stage  (flush_stage),
        .stage_valid  (stage_valid),
        .stage_data   (stage_data),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .halted       (halted),
        .state        (state)
`ifdef PIPE_PERF_EN
        ,
        .stall_cnt    (stall_cnt),
        .bubble_cnt   (bubble_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] sdat(input int k);
        return stage_data[k*WIDTH +: WIDTH];
    endfunction

    // Output side pops first, then the offered input is recorded with its due cycle.
    always @(negedge CLK) begin
        if (sb_en && out_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected_out", {32'd0, out_data}, 64'hDEAD);
            end else begin
                sb_item_t it;
                it = exp_q.pop_front();
                n_popped++;
                check_eq("sb_data", {32'd0, out_data}, {32'd0, it.data});
                check_eq("sb_cycle", 64'(cyc), 64'(it.due));
            end
        end
        if (sb_en && in_valid && !in_halt) begin
            exp_q.push_back('{data: in_data, due: cyc + DEPTH});
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid     = 1'b0;
        in_data      = '0;
        in_halt      = 1'b0;
        stall        = 1'b0;
        bubble_req   = 1'b0;
        bubble_stage = '0;
        flush_req    = 1'b0;
        flush_stage  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        nRST = 1'b0;
        step();
        step();
        nRST = 1'b1;
    endtask

    // Values enter in argument order, so the first ends up in stage DEPTH-1.
    task automatic fill4(input int a, input int b, input int c, input int d);
        int v[4];
        v = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = v[i];
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        nRST = 1'b0;
        idle_inputs();

        do_reset();
        check_eq("rst_valid", 64'(stage_valid), 64'h0);
        check_eq("rst_state", 64'(state), 64'h0);
        check_eq("rst_halted", 64'(halted), 64'h0);
        check_eq("rst_out_valid", 64'(out_valid), 64'h0);
        check_eq("rst_data3", 64'(sdat(3)), 64'h0);

        // Continuous shift through the scoreboard
        sb_en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1;
            in_data  = i;
            #1;
            check_eq("shift_ready", 64'(in_ready), 64'h1);
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) step();
        sb_en = 1'b0;
        check_eq("sb_pop_count", 64'(n_popped), 64'd6);
        check_eq("sb_leftover", 64'(exp_q.size()), 64'd0);

        // Bubble at stage 1, then the stage-0 boundary
        do_reset();
        fill4(4, 5, 6, 7);
        check_eq("fill_s0", 64'(sdat(0)), 64'd7);
        check_eq("fill_s3", 64'(sdat(3)), 64'd4);
        bubble_req   = 1'b1;
        bubble_stage = 2'd1;
        in_valid     = 1'b1;
        in_data      = 32'd99;
        #1;
        check_eq("bub_ready", 64'(in_ready), 64'h0);
        step();
        check_eq("bub_valid", 64'(stage_valid), 64'b1101);
        check_eq("bub_s0", 64'(sdat(0)), 64'd7);
        check_eq("bub_s1", 64'(sdat(1)), 64'd0);
        check_eq("bub_s2", 64'(sdat(2)), 64'd6);
        check_eq("bub_s3", 64'(sdat(3)), 64'd5);
        bubble_stage = 2'd0;
        step();
        check_eq("bub0_valid", 64'(stage_valid), 64'b1010);
        check_eq("bub0_s0", 64'(sdat(0)), 64'd0);
        check_eq("bub0_s1", 64'(sdat(1)), 64'd7);
        check_eq("bub0_s3", 64'(sdat(3)), 64'd6);

        // Flush younger entries; bubble request must be ignored alongside
        do_reset();
        fill4(6, 7, 8, 9);
        flush_req    = 1'b1;
        flush_stage  = 2'd1;
        bubble_req   = 1'b1;
        bubble_stage = 2'd3;
        in_valid     = 1'b1;
        in_data      = 32'd55;
        step();
        check_eq("flush_valid", 64'(stage_valid), 64'b1100);
        check_eq("flush_s2", 64'(sdat(2)), 64'd8);
        check_eq("flush_s3", 64'(sdat(3)), 64'd7);
        flush_stage = 2'd3;
        step();
        check_eq("flush_all_valid", 64'(stage_valid), 64'h0);

        // Stall freezes everything, even with requests asserted
        do_reset();
        fill4(1, 2, 3, 4);
        stall      = 1'b1;
        flush_req  = 1'b1;
        bubble_req = 1'b1;
        in_valid   = 1'b1;
        in_data    = 32'd77;
        #1;
        check_eq("stall_ready", 64'(in_ready), 64'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stall_valid", 64'(stage_valid), 64'hF);
            check_eq("stall_s0", 64'(sdat(0)), 64'd4);
            check_eq("stall_s3", 64'(sdat(3)), 64'd1);
        end
`ifdef PIPE_PERF_EN
        check_eq("stall_cnt", 64'(stall_cnt), 64'd3);
        check_eq("flush_cnt", 64'(flush_cnt), 64'd0);
`endif
        idle_inputs();

        // Halt drain: DRAIN next cycle, halted DEPTH edges after the accept
        do_reset();
        in_valid = 1'b1;
        in_halt  = 1'b1;
        in_data  = 32'hA;
        step();
        idle_inputs();
        check_eq("halt_state_drain", 64'(state), 64'd1);
        check_eq("halt_valid0", 64'(stage_valid), 64'b0001);
        for (int i = 1; i < DEPTH; i++) begin
            step();
            check_eq("halt_early", 64'(halted), 64'h0);
        end
        step();
        check_eq("halt_set", 64'(halted), 64'h1);
        check_eq("halt_state", 64'(state), 64'd2);
        in_valid = 1'b1;
        in_data  = 32'd5;
        #1;
        check_eq("halted_ready", 64'(in_ready), 64'h0);
        step();
        check_eq("halted_no_input", 64'(stage_valid[0]), 64'h0);
        idle_inputs();
        stall = 1'b1;
        step();
        step();
        check_eq("halted_stall", 64'(halted), 64'h1);
        check_eq("halted_stall_state", 64'(state), 64'd2);
        idle_inputs();

        // Flushes during DRAIN: one spares the marker, the next kills it
        do_reset();
        in_valid = 1'b1;
        in_halt  = 1'b1;
        in_data  = 32'hB;
        step();
        idle_inputs();
        step();
        flush_req   = 1'b1;
        flush_stage = 2'd0;
        step();
        check_eq("drain_flush_keep", 64'(state), 64'd1);
        check_eq("drain_flush_keep_v", 64'(stage_valid), 64'b0100);
        flush_stage = 2'd3;
        step();
        idle_inputs();
        check_eq("drain_flush_run", 64'(state), 64'd0);
        check_eq("drain_flush_v", 64'(stage_valid), 64'h0);

        // Reset mid-drain with every stage valid, overriding stall
        do_reset();
        fill4(1, 2, 3, 0);
        in_valid = 1'b1;
        in_halt  = 1'b1;
        in_data  = 32'd4;
        step();
        idle_inputs();
        check_eq("pre_rst_valid", 64'(stage_valid), 64'hF);
        check_eq("pre_rst_state", 64'(state), 64'd1);
        stall = 1'b1;
        nRST  = 1'b0;
        step();
        nRST = 1'b1;
        stall = 1'b0;
        check_eq("mid_rst_valid", 64'(stage_valid), 64'h0);
        check_eq("mid_rst_state", 64'(state), 64'd0);
        check_eq("mid_rst_halted", 64'(halted), 64'h0);
        check_eq("mid_rst_data0", 64'(sdat(0)), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
